// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor command sequencer.
// Holds the cmd_op encoding, the FSM state enum (its values are the state_o
// encoding), the speed counter width and the default cycle constants for a
// 100 MHz sys_clk.
package motor_ctrl_pkg;

    localparam int SPEED_W = 16;

    localparam int unsigned DEF_DWELL_CYC     = 50_000_000;  // 0.5 s
    localparam int unsigned DEF_RST_PULSE_CYC = 2_000;       // 20 us
    localparam int unsigned DEF_ALM_FILT_CYC  = 1_000;       // 10 us
    localparam int unsigned DEF_GATE_CYC      = 10_000_000;  // 100 ms
    localparam int unsigned DEF_MAX_RETRY     = 3;

    typedef enum logic [1:0] {
        OP_STOP      = 2'b00,
        OP_RUN_FWD   = 2'b01,
        OP_RUN_REV   = 2'b10,
        OP_CLR_ALARM = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_BRAKE    = 3'd2,
        ST_ALM_RST  = 3'd3,
        ST_ALM_WAIT = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

endpackage

// File: rtl/motor_seq_ctrl_if.sv
// Host command handshake for motor_seq_ctrl.
//   cmd_valid : command valid (host -> sequencer)
//   cmd_op    : 00 STOP, 01 RUN_FWD, 10 RUN_REV, 11 CLR_ALARM
//   cmd_ready : command taken when cmd_valid & cmd_ready
// master = host/register layer, slave = sequencer.
interface motor_seq_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);

endinterface

// File: rtl/motor_speed_meter.sv
// Speed measurement from the asynchronous speed_out pulse train.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   speed_i        : raw speed pulse (synchronized here)
//   speed_cnt_o    : rising edges counted in the last gate window (saturating)
//   speed_vld_o    : one-cycle strobe when speed_cnt_o updates
// The gate counter free-runs and wraps every GATE_CYC cycles.
module motor_speed_meter
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned GATE_CYC = DEF_GATE_CYC
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               speed_i,
    output logic [SPEED_W-1:0] speed_cnt_o,
    output logic               speed_vld_o
);

    localparam int GW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

    logic               sync1_q, sync2_q, prev_q;
    logic               rise;
    logic [GW-1:0]      gate_q;
    logic               gate_end;
    logic [SPEED_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [SPEED_W-1:0] speed_cnt_q;
    logic               speed_vld_q;

    assign rise     = sync2_q & ~prev_q;
    assign gate_end = (gate_q == GW'(GATE_CYC - 1));
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + SPEED_W'(1);

    // An edge on the boundary cycle opens the new window's count.
    always_comb begin
        cnt_d = cnt_q;
        if (gate_end)  cnt_d = rise ? SPEED_W'(1) : '0;
        else if (rise) cnt_d = cnt_inc;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            gate_q      <= '0;
            cnt_q       <= '0;
            speed_cnt_q <= '0;
            speed_vld_q <= 1'b0;
        end else begin
            sync1_q     <= speed_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            gate_q      <= gate_end ? '0 : gate_q + GW'(1);
            cnt_q       <= cnt_d;
            speed_vld_q <= gate_end;
            if (gate_end) speed_cnt_q <= cnt_q;
        end
    end

    assign speed_cnt_o = speed_cnt_q;
    assign speed_vld_o = speed_vld_q;

endmodule

// File: rtl/motor_seq_ctrl.sv
// Command sequencer for the BLE motor interface block.
// Enforces a stop dwell before reversal, runs bounded alarm-reset retries
// (latching FAULT after the last), and reports measured speed.
// Ports:
//   sys_clk, sys_rst   : 100 MHz clock, asynchronous active-low reset
//   cmd                : host command handshake (motor_seq_ctrl_if.slave)
//   motor_state        : run enable to the motor interface
//   motor_direction    : 1 = forward, 0 = reverse
//   motor_alarm_reset  : alarm reset request pulse
//   speed_out          : asynchronous speed pulse input
//   alarm_out_n        : asynchronous active-low alarm input
//   speed_cnt/speed_vld: last window's edge count and its update strobe
//   busy, fault, stall : status flags; state_o : FSM state encoding
// Build option: MOTOR_STALL_DETECT_EN adds the zero-speed stall fault in RUN.
module motor_seq_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_CYC     = DEF_DWELL_CYC,
    parameter int unsigned RST_PULSE_CYC = DEF_RST_PULSE_CYC,
    parameter int unsigned ALM_FILT_CYC  = DEF_ALM_FILT_CYC,
    parameter int unsigned GATE_CYC      = DEF_GATE_CYC,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    motor_seq_ctrl_if.slave    cmd,
    output logic               motor_state,
    output logic               motor_direction,
    output logic               motor_alarm_reset,
    input  logic               speed_out,
    input  logic               alarm_out_n,
    output logic [SPEED_W-1:0] speed_cnt,
    output logic               speed_vld,
    output logic               busy,
    output logic               fault,
    output logic               stall,
    output logic [2:0]         state_o
);

    localparam int unsigned TMR_MAX = (DWELL_CYC > RST_PULSE_CYC) ? DWELL_CYC : RST_PULSE_CYC;
    localparam int TMR_W  = $clog2(TMR_MAX + 1);
    localparam int FILT_W = $clog2(ALM_FILT_CYC + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [RTY_W-1:0]   retry_q;
    logic               motor_state_q, dir_q, alm_rst_q;
    logic               pend_run_q, pend_dir_q;
    logic               rdy_en_q;
    logic               alm_s1_q, alm_s2_q;
    logic [FILT_W-1:0]  filt_q;
    logic               alarm_det;
    logic               ready, accept;
    cmd_op_e            op;

    motor_speed_meter #(.GATE_CYC(GATE_CYC)) u_speed (
        .clk_i       (sys_clk),
        .rst_n_i     (sys_rst),
        .speed_i     (speed_out),
        .speed_cnt_o (speed_cnt),
        .speed_vld_o (speed_vld)
    );

    // Alarm synchronizer resets to the inactive level so reset release
    // cannot start the filter counting.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            alm_s1_q <= 1'b1;
            alm_s2_q <= 1'b1;
            filt_q   <= '0;
        end else begin
            alm_s1_q <= alarm_out_n;
            alm_s2_q <= alm_s1_q;
            if (alm_s2_q)        filt_q <= '0;
            else if (!alarm_det) filt_q <= filt_q + FILT_W'(1);
        end
    end

    assign alarm_det = (filt_q == FILT_W'(ALM_FILT_CYC));

    // rdy_en_q keeps cmd_ready low while reset is held.
    always_comb begin
        ready = 1'b0;
        if (rdy_en_q) begin
            case (state_q)
                ST_IDLE, ST_RUN: ready = ~alarm_det;
                ST_FAULT:        ready = 1'b1;
                default:         ready = 1'b0;
            endcase
        end
    end

    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid & ready;
    assign op            = cmd_op_e'(cmd.cmd_op);

`ifdef MOTOR_STALL_DETECT_EN
    // win_q counts window ends seen in RUN: the first is partial, the next
    // two are the skipped complete windows; from then on a zero count stalls.
    logic [1:0] win_q;
    logic       stall_q;
    logic       stall_hit;

    assign stall_hit = (state_q == ST_RUN) && !alarm_det && speed_vld &&
                       (win_q == 2'd3) && (speed_cnt == '0);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            win_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (state_q != ST_RUN)             win_q <= '0;
            else if (speed_vld && win_q != 2'd3) win_q <= win_q + 2'd1;
            if (stall_hit)                            stall_q <= 1'b1;
            else if (accept && op == OP_CLR_ALARM)    stall_q <= 1'b0;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            retry_q       <= '0;
            motor_state_q <= 1'b0;
            dir_q         <= 1'b0;
            alm_rst_q     <= 1'b0;
            pend_run_q    <= 1'b0;
            pend_dir_q    <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_RUN, ST_BRAKE: begin
                    if (alarm_det) begin
                        // Alarm outranks commands and dwell completion.
                        state_q       <= ST_ALM_RST;
                        timer_q       <= '0;
                        motor_state_q <= 1'b0;
                        alm_rst_q     <= 1'b1;
                        pend_run_q    <= 1'b0;
                    end else if (state_q == ST_IDLE) begin
                        if (accept && (op == OP_RUN_FWD || op == OP_RUN_REV)) begin
                            state_q       <= ST_RUN;
                            motor_state_q <= 1'b1;
                            dir_q         <= (op == OP_RUN_FWD);
                        end
                    end else if (state_q == ST_RUN) begin
`ifdef MOTOR_STALL_DETECT_EN
                        if (stall_hit) begin
                            state_q       <= ST_FAULT;
                            motor_state_q <= 1'b0;
                        end else
`endif
                        if (accept && op != OP_CLR_ALARM) begin
                            if (op == OP_STOP) begin
                                state_q       <= ST_BRAKE;
                                timer_q       <= '0;
                                motor_state_q <= 1'b0;
                                pend_run_q    <= 1'b0;
                            end else if ((op == OP_RUN_FWD) != dir_q) begin
                                state_q       <= ST_BRAKE;
                                timer_q       <= '0;
                                motor_state_q <= 1'b0;
                                pend_run_q    <= 1'b1;
                                pend_dir_q    <= (op == OP_RUN_FWD);
                            end
                        end
                    end else begin
                        if (timer_q == TMR_W'(DWELL_CYC - 1)) begin
                            timer_q <= '0;
                            if (pend_run_q) begin
                                state_q       <= ST_RUN;
                                motor_state_q <= 1'b1;
                                dir_q         <= pend_dir_q;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                            pend_run_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                end
                ST_ALM_RST: begin
                    if (timer_q == TMR_W'(RST_PULSE_CYC - 1)) begin
                        state_q   <= ST_ALM_WAIT;
                        timer_q   <= '0;
                        alm_rst_q <= 1'b0;
                        retry_q   <= retry_q + RTY_W'(1);
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_ALM_WAIT: begin
                    if (timer_q == TMR_W'(DWELL_CYC - 1)) begin
                        timer_q <= '0;
                        if (alm_s2_q) begin
                            state_q <= ST_IDLE;
                            retry_q <= '0;
                        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                            state_q   <= ST_ALM_RST;
                            alm_rst_q <= 1'b1;
                        end else begin
                            state_q <= ST_FAULT;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_FAULT: begin
                    motor_state_q <= 1'b0;
                    if (accept && op == OP_CLR_ALARM) begin
                        state_q   <= ST_ALM_RST;
                        timer_q   <= '0;
                        retry_q   <= '0;
                        alm_rst_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign motor_state       = motor_state_q;
    assign motor_direction   = dir_q;
    assign motor_alarm_reset = alm_rst_q;
    assign busy    = (state_q == ST_BRAKE) || (state_q == ST_ALM_RST) || (state_q == ST_ALM_WAIT);
    assign fault   = (state_q == ST_FAULT);
    assign state_o = state_q;

endmodule
